// File: rtl/receptor_quadro_serial.sv
// 8N1 UART frame receiver: rebuilds a sync-prefixed, XOR-checked frame and writes its payload
// byte by byte into an external frame buffer.
module receptor_quadro_serial #(
  parameter int unsigned CICLOS_POR_BIT = 434,
  parameter int unsigned BYTES_QUADRO   = 30,
  parameter logic [7:0]  BYTE_SYNC      = 8'hA5
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            entrada_serial,
  input  logic                            habilitar,
  output logic [7:0]                      dado,
  output logic [$clog2(BYTES_QUADRO)-1:0] endereco,
  output logic                            escrita,
  output logic                            quadro_pronto,
  output logic                            erro_checksum,
  output logic                            erro_enquadramento,
  output logic [7:0]                      quadros_recebidos,
  output logic [3:0]                      db_estado
);

  localparam int unsigned CW = $clog2(CICLOS_POR_BIT);
  localparam int unsigned AW = $clog2(BYTES_QUADRO);
  localparam logic [CW-1:0] FimBit    = CW'(CICLOS_POR_BIT - 1);
  localparam logic [CW-1:0] MeioBit   = CW'(CICLOS_POR_BIT / 2 - 1);
  localparam logic [AW-1:0] UltimoIdx = AW'(BYTES_QUADRO - 1);

  typedef enum logic [1:0] {
    RxOcioso = 2'd0,
    RxInicio = 2'd1,
    RxDados  = 2'd2,
    RxParada = 2'd3
  } estado_rx_e;

  typedef enum logic [1:0] {
    MtEsperaSync = 2'd0,
    MtCarga      = 2'd1,
    MtVerifica   = 2'd2
  } estado_mt_e;

  // Input synchronizer; flops reset to the idle (high) line level.
  logic sinc1_q, sinc2_q, linha;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sinc1_q <= 1'b1;
      sinc2_q <= 1'b1;
    end else begin
      sinc1_q <= entrada_serial;
      sinc2_q <= sinc1_q;
    end
  end

  assign linha = sinc2_q;

  // Bit receiver
  estado_rx_e    rx_q, rx_d;
  logic [CW-1:0] cont_q, cont_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    desloc_q, desloc_d;
  logic          byte_ok, erro_parada;
  logic          erro_enq_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_q       <= RxOcioso;
      cont_q     <= '0;
      bit_q      <= '0;
      desloc_q   <= '0;
      erro_enq_q <= 1'b0;
    end else begin
      rx_q       <= rx_d;
      cont_q     <= cont_d;
      bit_q      <= bit_d;
      desloc_q   <= desloc_d;
      erro_enq_q <= erro_parada;
    end
  end

  always_comb begin
    rx_d        = rx_q;
    cont_d      = cont_q + 1'b1;
    bit_d       = bit_q;
    desloc_d    = desloc_q;
    byte_ok     = 1'b0;
    erro_parada = 1'b0;
    case (rx_q)
      RxOcioso: begin
        cont_d = '0;
        if (!linha) rx_d = RxInicio;
      end
      RxInicio: begin
        if (cont_q == MeioBit) begin
          cont_d = '0;
          if (linha) begin
            rx_d = RxOcioso;
          end else begin
            rx_d  = RxDados;
            bit_d = '0;
          end
        end
      end
      RxDados: begin
        if (cont_q == FimBit) begin
          cont_d   = '0;
          desloc_d = {linha, desloc_q[7:1]};
          bit_d    = bit_q + 3'd1;
          if (bit_q == 3'd7) rx_d = RxParada;
        end
      end
      RxParada: begin
        if (cont_q == FimBit) begin
          cont_d = '0;
          rx_d   = RxOcioso;
          // byte_ok is combinational so the assembler's registered outputs land one cycle
          // after the stop-bit sample.
          if (linha) byte_ok = 1'b1;
          else       erro_parada = 1'b1;
        end
      end
      default: rx_d = RxOcioso;
    endcase
  end

  // Frame assembler
  estado_mt_e    mt_q, mt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [7:0]    chk_q, chk_d;
  logic [7:0]    dado_q, dado_d;
  logic [AW-1:0] end_q, end_d;
  logic          escrita_q, escrita_d;
  logic          pronto_q, pronto_d;
  logic          erro_chk_q, erro_chk_d;
  logic [7:0]    quadros_q, quadros_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mt_q       <= MtEsperaSync;
      idx_q      <= '0;
      chk_q      <= '0;
      dado_q     <= '0;
      end_q      <= '0;
      escrita_q  <= 1'b0;
      pronto_q   <= 1'b0;
      erro_chk_q <= 1'b0;
      quadros_q  <= '0;
    end else begin
      mt_q       <= mt_d;
      idx_q      <= idx_d;
      chk_q      <= chk_d;
      dado_q     <= dado_d;
      end_q      <= end_d;
      escrita_q  <= escrita_d;
      pronto_q   <= pronto_d;
      erro_chk_q <= erro_chk_d;
      quadros_q  <= quadros_d;
    end
  end

  always_comb begin
    mt_d       = mt_q;
    idx_d      = idx_q;
    chk_d      = chk_q;
    dado_d     = dado_q;
    end_d      = end_q;
    escrita_d  = 1'b0;
    pronto_d   = 1'b0;
    erro_chk_d = 1'b0;
    quadros_d  = quadros_q;
    if (!habilitar || erro_parada) begin
      // A framing error abandons the frame; writes already issued stay in the buffer.
      mt_d = MtEsperaSync;
    end else if (byte_ok) begin
      case (mt_q)
        MtEsperaSync: begin
          if (desloc_q == BYTE_SYNC) begin
            mt_d  = MtCarga;
            idx_d = '0;
            chk_d = '0;
          end
        end
        MtCarga: begin
          escrita_d = 1'b1;
          dado_d    = desloc_q;
          end_d     = idx_q;
          chk_d     = chk_q ^ desloc_q;
          idx_d     = idx_q + 1'b1;
          if (idx_q == UltimoIdx) mt_d = MtVerifica;
        end
        MtVerifica: begin
          if (desloc_q == chk_q) begin
            pronto_d  = 1'b1;
            quadros_d = quadros_q + 8'd1;
          end else begin
            erro_chk_d = 1'b1;
          end
          mt_d = MtEsperaSync;
        end
        default: mt_d = MtEsperaSync;
      endcase
    end
  end

  assign dado               = dado_q;
  assign endereco           = end_q;
  assign escrita            = escrita_q;
  assign quadro_pronto      = pronto_q;
  assign erro_checksum      = erro_chk_q;
  assign erro_enquadramento = erro_enq_q;
  assign quadros_recebidos  = quadros_q;
  assign db_estado          = {mt_q, rx_q};

endmodule
